// File: rtl/jtopl_snd_sink.sv
// jtopl_snd_sink
// Takes the finished sum from the operator accumulator, optionally removes its
// DC component with a leaky one-pole high-pass, applies a 0..3 bit gain with
// saturation and queues the result in a small show-ahead FIFO.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cenop, zero       accumulator enable / restart; both high = sum complete
//   snd   [W-1:0]     accumulator output, signed
//   dc_en             1 = DC-blocked path, 0 = raw path
//   gain  [1:0]       left shift applied after the filter
//   dout  [W-1:0]     FIFO head (zero while empty)
//   dout_valid        FIFO non-empty
//   dout_ready        consumer accept
//   ovr, clr_ovr      sticky overrun flag and its synchronous clear
//
// Pipeline: stb -> x (v1) -> filter/select (v2) -> gain/saturate (v3) -> FIFO.
// No back-pressure: a full FIFO drops the sample and raises ovr.
module jtopl_snd_sink #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int K     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cenop,
   input  logic         zero,
   input  logic [W-1:0] snd,
   input  logic         dc_en,
   input  logic [1:0]   gain,
   output logic [W-1:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         ovr,
   input  logic         clr_ovr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // filter state is kept at W+2 bits and clipped symmetrically
   localparam logic signed [W+1:0] Y_MAX = {1'b0, {(W+1){1'b1}}};
   localparam logic signed [W+1:0] Y_MIN = {1'b1, {W{1'b0}}, 1'b1};
   localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

   function automatic logic [W-1:0] sat_w(input logic signed [W+2:0] v);
      if (v > (W+3)'(S_MAX))
         return S_MAX;
      else if (v < (W+3)'(S_MIN))
         return S_MIN;
      else
         return v[W-1:0];
   endfunction

   logic                  stb;
   logic                  v1, v2, v3;
   logic signed [W-1:0]   x, xp, f;
   logic signed [W+1:0]   yp;
   logic [W-1:0]          d3;

   logic signed [W+3:0]   x_e, xp_e, yp_e, y_raw;
   logic signed [W+1:0]   y_sat;
   logic signed [W+2:0]   y_ext, f_ext, g;

   always_comb begin
      x_e   = {{4{x[W-1]}}, x};
      xp_e  = {{4{xp[W-1]}}, xp};
      yp_e  = {{2{yp[W+1]}}, yp};
      // (yp>>>K) is the leak that pulls the output back toward zero
      y_raw = x_e - xp_e + yp_e - (yp_e >>> K);
      if (y_raw > (W+4)'(Y_MAX))
         y_sat = Y_MAX;
      else if (y_raw < (W+4)'(Y_MIN))
         y_sat = Y_MIN;
      else
         y_sat = y_raw[W+1:0];
      y_ext = {y_sat[W+1], y_sat};
      f_ext = {{3{f[W-1]}}, f};
      g     = f_ext <<< gain;
   end

   // snd is only guaranteed fresh in the cycle after cenop&&zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb <= 1'b0;
         v1  <= 1'b0;
         v2  <= 1'b0;
         v3  <= 1'b0;
         x   <= '0;
         xp  <= '0;
         yp  <= '0;
         f   <= '0;
         d3  <= '0;
      end else begin
         stb <= cenop && zero;
         v1  <= stb;
         v2  <= v1;
         v3  <= v2;
         if (stb)
            x <= snd;
         // filter state advances on every sample so switching dc_en is glitch-free
         if (v1) begin
            xp <= x;
            yp <= y_sat;
            f  <= dc_en ? $signed(sat_w(y_ext)) : x;
         end
         if (v2)
            d3 <= sat_w(g);
      end
   end

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok, ovr_set;

   always_comb begin
      full    = (count == (AW+1)'(DEPTH));
      pop     = (count != '0) && dout_ready;
      // a simultaneous pop frees the slot, so the push still lands
      push_ok = v3 && (!full || pop);
      ovr_set = v3 && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= d3;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr    <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (ovr_set)
            ovr <= 1'b1;
         else if (clr_ovr)
            ovr <= 1'b0;
      end
   end

   assign dout_valid = (count != '0);
   assign dout       = dout_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_jtopl_snd_sink.sv
module tb_jtopl_snd_sink;

   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int K     = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cenop = 1'b0;
   logic         zero = 1'b0;
   logic [W-1:0] snd = '0;
   logic         dc_en = 1'b0;
   logic [1:0]   gain = 2'd0;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready = 1'b0;
   logic         ovr;
   logic         clr_ovr = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   jtopl_snd_sink #(.W(W), .DEPTH(DEPTH), .K(K)) dut (
      .clk(clk), .rst_n(rst_n), .cenop(cenop), .zero(zero), .snd(snd),
      .dc_en(dc_en), .gain(gain), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .ovr(ovr), .clr_ovr(clr_ovr)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each completed sum becomes one audio sample; the value is computed from
   // plain integer arithmetic, then released into a model queue four clock
   // edges after the enable edge (the design's documented latency).
   longint mxp, myp;
   int     mq[$];
   bit     movr;
   bit     mstb;
   bit     dv[1:3];
   int     dval[1:3];

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   function automatic int model_sample(input longint xin);
      longint y, fv, gv;
      longint ylim = (longint'(1) << (W+1)) - 1;
      y   = xin - mxp + myp - (myp >>> K);
      y   = clamp(y, -ylim, ylim);
      mxp = xin;
      myp = y;
      fv  = dc_en ? clamp(y, -(longint'(1) << (W-1)), (longint'(1) << (W-1)) - 1) : xin;
      gv  = fv * (longint'(1) << gain);
      return int'(clamp(gv, -(longint'(1) << (W-1)), (longint'(1) << (W-1)) - 1));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mxp = 0; myp = 0; movr = 0; mstb = 0;
         mq.delete();
         for (int i = 1; i <= 3; i++) begin dv[i] = 0; dval[i] = 0; end
      end else begin
         bit push, popm, fullm, set;
         push  = dv[3];
         popm  = (mq.size() > 0) && dout_ready;
         fullm = (mq.size() == DEPTH);
         set   = 0;
         if (popm) void'(mq.pop_front());
         if (push) begin
            if (fullm && !popm) set = 1;
            else mq.push_back(dval[3]);
         end
         if (set) movr = 1;
         else if (clr_ovr) movr = 0;
         dv[3] = dv[2]; dval[3] = dval[2];
         dv[2] = dv[1]; dval[2] = dval[1];
         dv[1] = mstb;
         if (mstb) dval[1] = model_sample(longint'($signed(snd)));
         mstb = cenop && zero;
      end
   end

   // ---------------- per-cycle compare ----------------
   int dut_out[$];

   always @(negedge clk) begin
      check("dout_valid", dout_valid, (mq.size() != 0));
      check("ovr", ovr, movr);
      if (mq.size() > 0 && dout_valid)
         check("dout", longint'($signed(dout)), mq[0]);
      if (!rst_n)
         check("dout_in_reset", dout, 0);
      if (rst_n && dout_valid && dout_ready)
         dut_out.push_back(int'($signed(dout)));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cenop = (i % 2 == 0);
         zero  = 1'b0;
         tick();
      end
      cenop = 1'b0;
   endtask

   task automatic strobe(input int v, input int gap);
      snd   = v[W-1:0];
      cenop = 1'b1;
      zero  = 1'b1;
      tick();
      cenop = 1'b0;
      zero  = 1'b0;
      idle(gap);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic chk_out(input string nm, input int pos, input int exp);
      if (pos >= dut_out.size())
         check({nm, "_missing"}, -1, exp);
      else
         check(nm, dut_out[pos], exp);
   endtask

   int base, lat;

   initial begin
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // raw path, gain 0, strobe every 8 clocks
      dc_en = 0; gain = 0; dout_ready = 1;
      base = dut_out.size();
      snd = 16'd1000; cenop = 1; zero = 1;
      tick();
      cenop = 0; zero = 0;
      lat = -1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (dout_valid) begin lat = i; break; end
      end
      check("first_valid_latency", lat, 4);
      idle(8 - lat);
      for (int i = 0; i < 3; i++) strobe(1000, 7);
      idle(4);
      for (int i = 0; i < 4; i++) chk_out("raw_1000", base + i, 1000);

      // DC blocker step response
      do_reset();
      dc_en = 1; gain = 0; dout_ready = 1;
      base = dut_out.size();
      strobe(0, 3);
      for (int i = 0; i < 4; i++) strobe(1000, 3);
      idle(6);
      chk_out("dc_step0", base + 0, 0);
      chk_out("dc_step1", base + 1, 1000);
      chk_out("dc_step2", base + 2, 997);
      chk_out("dc_step3", base + 3, 994);
      chk_out("dc_step4", base + 4, 991);

      // gain with saturation
      do_reset();
      dc_en = 0; gain = 3;
      base = dut_out.size();
      strobe(4096, 3);
      strobe(-5000, 3);
      strobe(-100, 3);
      idle(6);
      chk_out("gain_pos_sat", base + 0, 32767);
      chk_out("gain_neg_sat", base + 1, -32768);
      chk_out("gain_small", base + 2, -800);

      // overrun
      do_reset();
      dc_en = 0; gain = 0; dout_ready = 0;
      for (int v = 1; v <= 5; v++) strobe(v, 1);
      idle(6);
      check("ovr_after_5", ovr, 1);
      check("valid_when_full", dout_valid, 1);
      base = dut_out.size();
      dout_ready = 1;
      idle(8);
      for (int i = 0; i < 4; i++) chk_out("drain_order", base + i, i + 1);
      check("drained_count", dut_out.size() - base, 4);
      check("empty_after_drain", dout_valid, 0);
      clr_ovr = 1;
      tick();
      clr_ovr = 0;
      check("ovr_cleared", ovr, 0);

      // clear coinciding with a fresh overrun: set wins
      dout_ready = 0;
      for (int v = 21; v <= 24; v++) strobe(v, 1);
      idle(4);
      clr_ovr = 1;
      strobe(25, 3);
      @(posedge clk); #1;
      check("set_beats_clear", ovr, 1);
      #1;
      tick();
      clr_ovr = 0;
      check("ovr_after_clear_hold", ovr, 0);
      dout_ready = 1;
      idle(8);

      // full FIFO with push and pop in the same cycle
      do_reset();
      dout_ready = 0;
      for (int v = 11; v <= 14; v++) strobe(v, 1);
      idle(6);
      base = dut_out.size();
      snd = 16'd15; cenop = 1; zero = 1;
      tick();
      cenop = 0; zero = 0;
      tick(); tick(); tick();
      dout_ready = 1;
      tick();
      dout_ready = 0;
      tick();
      check("no_ovr_push_pop", ovr, 0);
      dout_ready = 1;
      idle(8);
      for (int i = 0; i < 5; i++) chk_out("push_pop_order", base + i, 11 + i);

      // reset mid-operation
      do_reset();
      dc_en = 1; gain = 0; dout_ready = 0;
      strobe(100, 1);
      strobe(200, 6);
      check("two_queued", dout_valid, 1);
      snd = 16'd300; cenop = 1; zero = 1;
      tick();
      cenop = 0; zero = 0;
      tick(); tick();
      rst_n = 0;
      #1;
      check("async_valid_clear", dout_valid, 0);
      check("async_dout_clear", dout, 0);
      tick(); tick();
      rst_n = 1;
      idle(8);
      check("no_output_after_release", dout_valid, 0);
      dout_ready = 1;
      base = dut_out.size();
      strobe(500, 7);
      chk_out("filter_restart", base, 500);
      check("single_after_restart", dut_out.size() - base, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
